// File: rtl/ndrot_pkg.sv
// ---------------------------------------------------------------------------
// ndrot_pkg
//   Shared definitions for the clocked NDRO (non-destructive readout) cell.
//   - ndro_state_t : stored-bit state (ST_ZERO / ST_ONE)
//   - OUT_MODE_*   : output encoding selectors for the OUT_TOGGLE parameter
//   - DEFAULT_CNT_W: default width of the optional read counter
//   Configuration macro honoured by users of this package: NDROT_READ_CNT_EN
// ---------------------------------------------------------------------------
package ndrot_pkg;

  // Stored-bit state of the cell; encoding matches the observable q value
  typedef enum logic {
    ST_ZERO = 1'b0,
    ST_ONE  = 1'b1
  } ndro_state_t;

  // Output encoding: pulse = high for one cycle per read-1, toggle = flip per read-1
  localparam int OUT_MODE_PULSE  = 0;
  localparam int OUT_MODE_TOGGLE = 1;

  // Default width of the read-pulse counter
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/ndrot_toggle_det.sv
// ---------------------------------------------------------------------------
// ndrot_toggle_det
//   Converts a toggle-encoded pulse line into a one-cycle event: every change
//   of din since the previous clock rise is reported as ev=1.
//   Ports:
//     clk   in  1  sampling clock (rising edge)
//     reset in  1  asynchronous active-high reset, clears the sampled copy
//     din   in  1  toggle-encoded pulse input
//     ev    out 1  combinational event flag (din differs from last sample)
// ---------------------------------------------------------------------------
module ndrot_toggle_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic ev
);

  logic din_prev;

  // Remember the line level seen at the last clock rise. Clearing it to 0 on
  // reset means a line held at 1 across the first edge counts as one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_prev <= 1'b0;
    end else begin
      din_prev <= din;
    end
  end

  assign ev = din ^ din_prev;

endmodule

// File: rtl/mitll_ndrot_cell.sv
// ---------------------------------------------------------------------------
// mitll_ndrot_cell
//   Clocked equivalent of an RSFQ non-destructive readout cell. A set pulse
//   (toggle-encoded) stores a 1; every clock rise reads the stored bit without
//   clearing it and emits an output pulse when the bit is 1.
//   Parameters:
//     OUT_TOGGLE 1: out flips once per read-1; 0: out high one cycle per read-1
//     CNT_W      width of rd_cnt
//   Ports:
//     clk    in  1      clock, each rising edge is one readout
//     reset  in  1      asynchronous active-high, clears all state
//     set    in  1      toggle-encoded set pulse input
//     out    out 1      readout pulse output
//     q      out 1      registered stored bit
//     rd_cnt out CNT_W  saturating count of read-1 pulses (NDROT_READ_CNT_EN)
//   Configuration macro: NDROT_READ_CNT_EN adds the rd_cnt port and counter.
// ---------------------------------------------------------------------------
module mitll_ndrot_cell
  import ndrot_pkg::*;
#(
  parameter int OUT_TOGGLE = OUT_MODE_TOGGLE,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  output logic             out,
`ifdef NDROT_READ_CNT_EN
  output logic [CNT_W-1:0] rd_cnt,
`endif
  output logic             q
);

  ndro_state_t state_q;
  ndro_state_t state_d;
  logic        set_ev;
  logic        rd;
  logic        out_d;

  ndrot_toggle_det u_set_det (
    .clk   (clk),
    .reset (reset),
    .din   (set),
    .ev    (set_ev)
  );

  // Next state and readout. A set arriving in the same cycle as a read is
  // applied first, so the read sees the freshly stored 1. Sets are idempotent
  // and a read never clears the bit.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    out_d   = 1'b0;
    if (set_ev) begin
      state_d = ST_ONE;
    end
    rd = (state_d == ST_ONE);
    if (OUT_TOGGLE != OUT_MODE_PULSE) begin
      out_d = out ^ rd;
    end else begin
      out_d = rd;
    end
  end

  // State and output registers; reset dominates and drops any pending read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ZERO;
      out     <= 1'b0;
    end else begin
      state_q <= state_d;
      out     <= out_d;
    end
  end

  assign q = (state_q == ST_ONE);

`ifdef NDROT_READ_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count read-1 pulses, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rd && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mitll_ndrot_cell.sv
// ---------------------------------------------------------------------------
// tb_mitll_ndrot_cell
//   Bench for mitll_ndrot_cell. Two instances share the inputs: dut_t in
//   toggle mode (CNT_W=8) and dut_p in pulse mode (CNT_W=2). A directed
//   vector table, a randomized phase compared against a behavioural model,
//   and hand-written sequences for mid-cycle reset and counter saturation.
//   Honours NDROT_READ_CNT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_mitll_ndrot_cell;

  logic clk;
  logic reset;
  logic set;
  logic out_t, q_t, out_p, q_p;
`ifdef NDROT_READ_CNT_EN
  logic [7:0] cnt_t;
  logic [1:0] cnt_p;
`endif

  int checks;
  int fails;

  // Behavioural model: stored bit, read count since reset, last sampled set
  logic m_prev;
  logic m_q;
  int   m_reads;

  typedef struct {
    logic rst;
    logic set_in;
    logic exp_q;
    logic exp_out_t;
    logic exp_out_p;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[11];

  mitll_ndrot_cell #(.OUT_TOGGLE(1), .CNT_W(8)) dut_t (
    .clk    (clk),
    .reset  (reset),
    .set    (set),
    .out    (out_t),
`ifdef NDROT_READ_CNT_EN
    .rd_cnt (cnt_t),
`endif
    .q      (q_t)
  );

  mitll_ndrot_cell #(.OUT_TOGGLE(0), .CNT_W(2)) dut_p (
    .clk    (clk),
    .reset  (reset),
    .set    (set),
    .out    (out_p),
`ifdef NDROT_READ_CNT_EN
    .rd_cnt (cnt_p),
`endif
    .q      (q_p)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_prev  = 1'b0;
    m_q     = 1'b0;
    m_reads = 0;
  endtask

  // One readout edge in spec terms: a changed set line stores a 1, then a
  // stored 1 produces one read pulse.
  task automatic model_edge(input logic s);
    if (s != m_prev) m_q = 1'b1;
    m_prev = s;
    if (m_q) m_reads++;
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, sample 1 unit later
  task automatic apply_stimulus(input logic r, input logic s);
    @(negedge clk);
    reset = r;
    set   = s;
    if (r) model_reset();
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_edge(s);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".q_t"},   int'(q_t),   int'(m_q));
    check_output({tag, ".out_t"}, int'(out_t), m_reads % 2);
    check_output({tag, ".q_p"},   int'(q_p),   int'(m_q));
    check_output({tag, ".out_p"}, int'(out_p), int'(m_q));
`ifdef NDROT_READ_CNT_EN
    check_output({tag, ".cnt_t"}, int'(cnt_t), sat(m_reads, 255));
    check_output({tag, ".cnt_p"}, int'(cnt_p), sat(m_reads, 3));
`endif
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    set    = 1'b0;
    model_reset();

    //            rst   set   q     outT  outP  cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2};

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].set_in);
      check_output($sformatf("vec%0d.q_t", i),   int'(q_t),   int'(vecs[i].exp_q));
      check_output($sformatf("vec%0d.out_t", i), int'(out_t), int'(vecs[i].exp_out_t));
      check_output($sformatf("vec%0d.q_p", i),   int'(q_p),   int'(vecs[i].exp_q));
      check_output($sformatf("vec%0d.out_p", i), int'(out_p), int'(vecs[i].exp_out_p));
`ifdef NDROT_READ_CNT_EN
      check_output($sformatf("vec%0d.cnt_t", i), int'(cnt_t), vecs[i].exp_cnt);
      check_output($sformatf("vec%0d.cnt_p", i), int'(cnt_p), sat(vecs[i].exp_cnt, 3));
`endif
    end

    $display("[TB] randomized phase against model");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] mid-cycle reset with stored 1");
    apply_stimulus(1'b0, ~set);
    check_output("pre_rst.q_t", int'(q_t), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    set   = 1'b0;
    model_reset();
    #1;
    check_output("mid_rst.q_t",   int'(q_t),   0);
    check_output("mid_rst.out_t", int'(out_t), 0);
    check_output("mid_rst.q_p",   int'(q_p),   0);
    check_output("mid_rst.out_p", int'(out_p), 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b0);
    check_output("post_rst.q_t",   int'(q_t),   0);
    check_output("post_rst.out_t", int'(out_t), 0);
    check_model("post_rst");

    $display("[TB] pulse mode saturation");
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output($sformatf("sat%0d.out_p", i), int'(out_p), 1);
      check_model($sformatf("sat%0d", i));
    end
`ifdef NDROT_READ_CNT_EN
    check_output("sat.cnt_p", int'(cnt_p), 3);
    check_output("sat.cnt_t", int'(cnt_t), 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
